// File: rtl/gps_dsp_pkg.sv
// Shared widths and types for the carrier mixer datapath.
package gps_dsp_pkg;
  localparam int ADC_W       = 8;
  localparam int NCO_ACC_W   = 32;
  localparam int LUT_ADDR_W  = 8;
  localparam int LUT_AMP_W   = 8;
  localparam int MIX_W       = 16;
  localparam int MIX_LATENCY = 3;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quadrant_e;
endpackage

// File: rtl/nco_sincos_lut.sv
// Quarter-wave sine ROM with quadrant fold; registered signed sin/cos, one cycle latency.
module nco_sincos_lut
  import gps_dsp_pkg::*;
(
  input  logic                        clk,
  input  logic                        en,
  input  quadrant_e                   quad,
  input  logic [LUT_ADDR_W-1:0]       addr,
  output logic signed [LUT_AMP_W-1:0] sin_val,
  output logic signed [LUT_AMP_W-1:0] cos_val
);
  localparam int DEPTH = 1 << LUT_ADDR_W;

  // Half-step offset keeps the table symmetric, so cos is the table read backwards.
  function automatic logic [LUT_AMP_W-1:0] quarter_sin(input int k);
    real ang;
    ang = 2.0 * 3.14159265358979 * (real'(k) + 0.5) / real'(4 * DEPTH);
    return LUT_AMP_W'($rtoi(127.0 * $sin(ang) + 0.5));
  endfunction

  logic [LUT_AMP_W-1:0] rom [DEPTH];
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom[k] = quarter_sin(k);
  end

  logic signed [LUT_AMP_W-1:0] lo, hi;
  logic signed [LUT_AMP_W-1:0] sin_next, cos_next;

  always_comb begin
    lo = signed'(rom[addr]);
    hi = signed'(rom[~addr]);
    sin_next = '0;
    cos_next = '0;
    unique case (quad)
      QUAD_0: begin sin_next = lo;  cos_next = hi;  end
      QUAD_1: begin sin_next = hi;  cos_next = -lo; end
      QUAD_2: begin sin_next = -lo; cos_next = -hi; end
      default: begin sin_next = -hi; cos_next = lo; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (en) begin
      sin_val <= sin_next;
      cos_val <= cos_next;
    end
  end
endmodule

// File: rtl/carrier_mixer_nco.sv
// Carrier NCO with loop-corrected frequency word, mixing IF samples down to I/Q baseband.
module carrier_mixer_nco
  import gps_dsp_pkg::*;
#(
  parameter logic [NCO_ACC_W-1:0] FCW_NOM = 32'h4000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [ADC_W-1:0]     adc_in,
  input  logic                        adc_valid,
  input  logic signed [NCO_ACC_W-1:0] correction,
  input  logic                        corr_valid,
  output logic signed [MIX_W-1:0]     out_i,
  output logic signed [MIX_W-1:0]     out_q,
  output logic                        out_valid
);
  logic [NCO_ACC_W-1:0]        acc, fcw;
  logic signed [ADC_W-1:0]     adc_p0, adc_p1;
  quadrant_e                   quad_p0;
  logic [LUT_ADDR_W-1:0]       addr_p0;
  logic signed [LUT_AMP_W-1:0] sin_p1, cos_p1;
  logic                        vld_p0, vld_p1, vld_p2;

  // Full-precision product; |128*127| always fits MIX_W.
  function automatic logic signed [MIX_W-1:0] mix(input logic signed [ADC_W-1:0] a,
                                                   input logic signed [LUT_AMP_W-1:0] b);
    logic signed [MIX_W-1:0] ax, bx;
    ax = MIX_W'(a);
    bx = MIX_W'(b);
    return ax * bx;
  endfunction

  // A sample arriving with a correction still steps by the old fcw.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      fcw <= FCW_NOM;
    end else begin
      if (corr_valid) fcw <= FCW_NOM + $unsigned(correction);
      if (adc_valid)  acc <= acc + fcw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= adc_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // S1: capture sample with the phase it sees
  always_ff @(posedge clk) begin
    if (adc_valid) begin
      adc_p0  <= adc_in;
      quad_p0 <= quadrant_e'(acc[NCO_ACC_W-1 -: 2]);
      addr_p0 <= acc[NCO_ACC_W-3 -: LUT_ADDR_W];
    end
  end

  // S2: table read and fold
  nco_sincos_lut u_lut (
    .clk     (clk),
    .en      (vld_p0),
    .quad    (quad_p0),
    .addr    (addr_p0),
    .sin_val (sin_p1),
    .cos_val (cos_p1)
  );

  always_ff @(posedge clk) begin
    if (vld_p0) adc_p1 <= adc_p0;
  end

  // S3: mix; outputs hold between valid samples
  always_ff @(posedge clk) begin
    if (rst) begin
      out_i <= '0;
      out_q <= '0;
    end else if (vld_p1) begin
      out_i <= mix(adc_p1, cos_p1);
      out_q <= -mix(adc_p1, sin_p1);
    end
  end

  assign out_valid = vld_p2;
endmodule

// File: doc/carrier_mixer_nco.md
CARRIER_MIXER_NCO -- requirements
Module: carrier_mixer_nco

Interface
REQ-001 Parameter FCW_NOM, 32'h4000_0000: nominal frequency control word, unsigned, cycles per sample = FCW_NOM/2^32.
REQ-002 Port clk  input  1  single processing clock; all logic on its rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port adc_in  input  signed 8  IF sample.
REQ-005 Port adc_valid  input  1  adc_in valid this cycle; no backpressure.
REQ-006 Port correction  input  signed 32  carrier loop correction from the Costas filter.
REQ-007 Port corr_valid  input  1  correction valid this cycle.
REQ-008 Port out_i  output  signed 16  in-phase baseband product.
REQ-009 Port out_q  output  signed 16  quadrature baseband product.
REQ-010 Port out_valid  output  1  out_i/out_q valid this cycle.

Function
REQ-011 32-bit phase accumulator acc; fcw register 32 bits; both wrap modulo 2^32, no saturation.
REQ-012 On corr_valid, fcw <= FCW_NOM + correction (two's complement, mod 2^32); the new value is first used by the next accepted sample after the update cycle.
REQ-013 corr_valid and adc_valid in the same cycle: that sample uses the old fcw.
REQ-014 On adc_valid, the sample is processed with the current acc, and acc <= acc + fcw; without adc_valid, acc holds.
REQ-015 Phase index = acc[31:22] (1024 points/cycle); top 2 bits select quadrant, the lower 8 bits address a 256-entry quarter-wave table.
REQ-016 Table entry k = round(127*sin(2*pi*(k+0.5)/1024)), range 0..127; cos and sin derived by quadrant fold and sign, giving signed 8-bit values in -127..127.
REQ-017 out_i = adc_in * cos(phase); out_q = -(adc_in * sin(phase)); full-precision 16-bit signed, no rounding or saturation (magnitude max 128*127 fits).
REQ-018 Pipeline 3 stages: S1 register sample/index/quadrant, S2 registered table read with fold, S3 registered multiply; out_valid asserts exactly 3 cycles after adc_valid.
REQ-019 Valid bubbles propagate unchanged; back-to-back samples give one output per cycle; out_i/out_q hold their last value while out_valid=0.

Reset
REQ-020 While rst=1 at a clock edge: acc=0, fcw=FCW_NOM, all pipeline valids=0, out_i=0, out_q=0, out_valid=0.
REQ-021 rst mid-stream discards in-flight samples; first sample accepted after rst deasserts uses phase 0 and FCW_NOM.
REQ-022 rst has priority over corr_valid and adc_valid in the same cycle.

Structure
REQ-023 Shared package gps_dsp_pkg holds ADC_W=8, NCO_ACC_W=32, LUT_ADDR_W=8, LUT_AMP_W=8, MIX_W=16, MIX_LATENCY=3 and the quadrant enum typedef.
REQ-024 One sub-module nco_sincos_lut: registered quarter-wave ROM plus quadrant fold, 1-cycle latency, outputs signed sin and cos.

Verification
REQ-025 FCW_NOM=2^30, no correction, adc_in=100 continuous -> out_i repeats 12700,0,-12700,0; out_q repeats 0,-12700,0,12700.
REQ-026 Single adc_valid pulse at cycle t -> out_valid high only at t+3; zero spurious valids for 20 idle cycles.
REQ-027 FCW_NOM=2^30, corr_valid with correction=-2^30 -> fcw=0; subsequent samples of adc_in=50 give constant out_i=50*cos of the frozen phase.
REQ-028 FCW_NOM=32'h8000_0000, correction=32'h8000_0000 -> fcw wraps to 0; correction=32'h7FFF_FFFF -> fcw=32'hFFFF_FFFF (phase steps backward).
REQ-029 adc_valid on alternate cycles with fs/4 setting -> output sequence identical to REQ-025, spaced 2 cycles apart.
REQ-030 rst pulse with 2 samples in flight -> neither emerges; next sample yields out_i=adc_in*127, out_q=0 after 3 cycles.
